// File: rtl/mc_control_unit_if.sv
// Handshake and control bundle between the instruction register/datapath and mc_control_unit.
// The datapath side (master) drives the decoded fields and memory ready; the control unit (slave) drives controls.
interface mc_control_unit_if #(
    parameter int ALUOP_W = 5
) ();
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic               mem_ready;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic               Branch;
    logic               Jump;
    logic               JumpReg;
    logic               RegDest;
    logic               MemToReg;
    logic               Link;
    logic               ALUsrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic               illegal;
    logic               retire;
    logic [2:0]         state;

    modport master (
        output opcode, func, mem_ready,
        input  IorD, IRWrite, PCWrite, Branch, Jump, JumpReg, RegDest, MemToReg, Link,
               ALUsrc, ALUOp, MemRead, MemWrite, RegWrite, illegal, retire, state
    );

    modport slave (
        input  opcode, func, mem_ready,
        output IorD, IRWrite, PCWrite, Branch, Jump, JumpReg, RegDest, MemToReg, Link,
               ALUsrc, ALUOp, MemRead, MemWrite, RegWrite, illegal, retire, state
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction through FETCH/DECODE/EXEC/MEM/MULDIV/WB
// with memory-ready stalls, a fixed-length MULT/DIV stall, illegal-instruction flagging and a retire pulse.
//
// state  | meaning
// FETCH  | read instruction at PC; on mem_ready load IR and PC+4
// DECODE | latch opcode/func; jumps and illegal instructions finish here
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data memory access for LW/SW, stalled on mem_ready
// MULDIV | remaining MULT/DIV cycles, ALUOp held
// WB     | register file write, retire
module mc_control_unit #(
    parameter int ALUOP_W       = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MULDIV = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LW = 6'h23, OP_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                           FN_SRLV = 6'h06, FN_JR = 6'h08, FN_MULT = 6'h18, FN_DIV = 6'h1A,
                           FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                           FN_SLT = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0), ALU_SUB = ALUOP_W'(1),
                                   ALU_AND = ALUOP_W'(2), ALU_OR = ALUOP_W'(3),
                                   ALU_XOR = ALUOP_W'(4), ALU_NOR = ALUOP_W'(5),
                                   ALU_SLT = ALUOP_W'(6), ALU_SLL = ALUOP_W'(7),
                                   ALU_SRL = ALUOP_W'(8), ALU_SRA = ALUOP_W'(9),
                                   ALU_SLLV = ALUOP_W'(10), ALU_SRLV = ALUOP_W'(11),
                                   ALU_MULT = ALUOP_W'(12), ALU_DIV = ALUOP_W'(13),
                                   ALU_COMP_EQ = ALUOP_W'(14), ALU_COMP_NEQ = ALUOP_W'(15),
                                   ALU_COMP_GT = ALUOP_W'(16), ALU_COMP_LT = ALUOP_W'(17);

    localparam logic [3:0] MD_LOAD = (MULDIV_CYCLES > 1) ? 4'(MULDIV_CYCLES - 2) : 4'd0;

    state_t     st;
    logic [3:0] cnt;
    logic [5:0] op_q;
    logic [5:0] fn_q;

    // In DECODE the IR fields are still being latched, so decode straight from the inputs.
    logic [5:0] op;
    logic [5:0] fn;
    assign op = (st == S_DECODE) ? bus.opcode : op_q;
    assign fn = (st == S_DECODE) ? bus.func   : fn_q;

    logic is_r, is_j, is_jal, is_jr, is_md, is_br, is_lw, is_sw, is_imm, legal_fn, legal;
    logic [ALUOP_W-1:0] alu_sel;

    always_comb begin
        is_r   = (op == OP_R);
        is_j   = (op == OP_J);
        is_jal = (op == OP_JAL);
        is_jr  = is_r && (fn == FN_JR);
        is_md  = is_r && ((fn == FN_MULT) || (fn == FN_DIV));
        is_br  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
        is_lw  = (op == OP_LW);
        is_sw  = (op == OP_SW);
        is_imm = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
                 (op == OP_ORI) || (op == OP_XORI);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_JR, FN_MULT, FN_DIV, FN_ADD, FN_ADDU,
            FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: legal_fn = 1'b1;
            default:                                                 legal_fn = 1'b0;
        endcase
        legal = is_r ? legal_fn : (is_j || is_jal || is_br || is_imm || is_lw || is_sw);
    end

    always_comb begin
        alu_sel = ALU_ADD;
        if (is_r) begin
            case (fn)
                FN_SLL:          alu_sel = ALU_SLL;
                FN_SRL:          alu_sel = ALU_SRL;
                FN_SRA:          alu_sel = ALU_SRA;
                FN_SLLV:         alu_sel = ALU_SLLV;
                FN_SRLV:         alu_sel = ALU_SRLV;
                FN_MULT:         alu_sel = ALU_MULT;
                FN_DIV:          alu_sel = ALU_DIV;
                FN_SUB, FN_SUBU: alu_sel = ALU_SUB;
                FN_AND:          alu_sel = ALU_AND;
                FN_OR:           alu_sel = ALU_OR;
                FN_XOR:          alu_sel = ALU_XOR;
                FN_NOR:          alu_sel = ALU_NOR;
                FN_SLT:          alu_sel = ALU_SLT;
                default:         alu_sel = ALU_ADD;
            endcase
        end else begin
            // Branch compares are inverted so that ALU zero means "taken".
            case (op)
                OP_ANDI: alu_sel = ALU_AND;
                OP_ORI:  alu_sel = ALU_OR;
                OP_XORI: alu_sel = ALU_XOR;
                OP_BEQ:  alu_sel = ALU_COMP_NEQ;
                OP_BNE:  alu_sel = ALU_COMP_EQ;
                OP_BLEZ: alu_sel = ALU_COMP_GT;
                OP_BGTZ: alu_sel = ALU_COMP_LT;
                default: alu_sel = ALU_ADD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_FETCH;
            cnt  <= 4'd0;
            op_q <= 6'd0;
            fn_q <= 6'd0;
        end else begin
            case (st)
                S_FETCH:  if (bus.mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    op_q <= bus.opcode;
                    fn_q <= bus.func;
                    st   <= (!legal || is_j || is_jal || is_jr) ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    if (is_br)
                        st <= S_FETCH;
                    else if (is_md) begin
                        if (MULDIV_CYCLES == 1)
                            st <= S_WB;
                        else begin
                            cnt <= MD_LOAD;
                            st  <= S_MULDIV;
                        end
                    end else if (is_lw || is_sw)
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_MULDIV: begin
                    if (cnt == 4'd0) st <= S_WB;
                    else             cnt <= cnt - 4'd1;
                end
                S_MEM:    if (bus.mem_ready) st <= is_lw ? S_WB : S_FETCH;
                S_WB:     st <= S_FETCH;
                default:  st <= S_FETCH;
            endcase
        end
    end

    logic iord_c, irwrite_c, pcwrite_c, branch_c, jump_c, jumpreg_c, regdest_c, memtoreg_c;
    logic link_c, alusrc_c, memread_c, memwrite_c, regwrite_c, illegal_c, retire_c;
    logic [ALUOP_W-1:0] alu_c;

    always_comb begin
        {iord_c, irwrite_c, pcwrite_c, branch_c, jump_c, jumpreg_c, regdest_c, memtoreg_c,
         link_c, alusrc_c, memread_c, memwrite_c, regwrite_c, illegal_c, retire_c} = '0;
        alu_c = '0;
        case (st)
            S_FETCH: begin
                memread_c = 1'b1;
                irwrite_c = bus.mem_ready;
                pcwrite_c = bus.mem_ready;
            end
            S_DECODE: begin
                if (!legal)
                    illegal_c = 1'b1;
                else if (is_j || is_jal || is_jr) begin
                    jump_c     = 1'b1;
                    jumpreg_c  = is_jr;
                    pcwrite_c  = 1'b1;
                    regwrite_c = is_jal;
                    retire_c   = 1'b1;
                end
            end
            S_EXEC: begin
                alu_c    = alu_sel;
                alusrc_c = is_imm || is_lw || is_sw;
                branch_c = is_br;
                retire_c = is_br;
            end
            S_MULDIV: alu_c = alu_sel;
            S_MEM: begin
                iord_c     = 1'b1;
                alusrc_c   = 1'b1;
                alu_c      = ALU_ADD;
                memread_c  = is_lw;
                memwrite_c = is_sw;
                retire_c   = is_sw && bus.mem_ready;
            end
            S_WB: begin
                regwrite_c = 1'b1;
                link_c     = 1'b1;
                retire_c   = 1'b1;
                regdest_c  = is_r;
                memtoreg_c = is_lw;
            end
            default: ;
        endcase
    end

    // Outputs are held at 0 for the whole time reset is asserted, not just until the next edge.
    assign bus.IorD     = rst_n & iord_c;
    assign bus.IRWrite  = rst_n & irwrite_c;
    assign bus.PCWrite  = rst_n & pcwrite_c;
    assign bus.Branch   = rst_n & branch_c;
    assign bus.Jump     = rst_n & jump_c;
    assign bus.JumpReg  = rst_n & jumpreg_c;
    assign bus.RegDest  = rst_n & regdest_c;
    assign bus.MemToReg = rst_n & memtoreg_c;
    assign bus.Link     = rst_n & link_c;
    assign bus.ALUsrc   = rst_n & alusrc_c;
    assign bus.MemRead  = rst_n & memread_c;
    assign bus.MemWrite = rst_n & memwrite_c;
    assign bus.RegWrite = rst_n & regwrite_c;
    assign bus.illegal  = rst_n & illegal_c;
    assign bus.retire   = rst_n & retire_c;
    assign bus.ALUOp    = rst_n ? alu_c : '0;
    assign bus.state    = rst_n ? st : 3'd0;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle expected state/ALUOp/control vectors for each instruction class.
module tb_mc_control_unit;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_control_unit_if #(.ALUOP_W(5)) ifc  ();
    mc_control_unit_if #(.ALUOP_W(5)) ifc1 ();

    mc_control_unit #(.ALUOP_W(5), .MULDIV_CYCLES(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
    mc_control_unit #(.ALUOP_W(5), .MULDIV_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: IorD IRWrite PCWrite Branch Jump JumpReg RegDest MemToReg Link ALUsrc MemRead MemWrite RegWrite illegal retire
    localparam logic [14:0] IO = 15'h4000, IW = 15'h2000, PW = 15'h1000, BR = 15'h0800,
                            JP = 15'h0400, JR = 15'h0200, RD = 15'h0100, MT = 15'h0080,
                            LK = 15'h0040, AS = 15'h0020, MR = 15'h0010, MW = 15'h0008,
                            RW = 15'h0004, IL = 15'h0002, RT = 15'h0001;
    localparam logic [14:0] FRDY = MR | IW | PW;
    localparam logic [4:0]  A_ADD = 5'd0, A_SUB = 5'd1, A_OR = 5'd3, A_MULT = 5'd12,
                            A_CNEQ = 5'd15, A_CLT = 5'd17;

    logic [14:0] ctl, ctl1;
    logic [22:0] obs, obs1;
    assign ctl  = {ifc.IorD, ifc.IRWrite, ifc.PCWrite, ifc.Branch, ifc.Jump, ifc.JumpReg,
                   ifc.RegDest, ifc.MemToReg, ifc.Link, ifc.ALUsrc, ifc.MemRead, ifc.MemWrite,
                   ifc.RegWrite, ifc.illegal, ifc.retire};
    assign ctl1 = {ifc1.IorD, ifc1.IRWrite, ifc1.PCWrite, ifc1.Branch, ifc1.Jump, ifc1.JumpReg,
                   ifc1.RegDest, ifc1.MemToReg, ifc1.Link, ifc1.ALUsrc, ifc1.MemRead, ifc1.MemWrite,
                   ifc1.RegWrite, ifc1.illegal, ifc1.retire};
    assign obs  = {ifc.state, ifc.ALUOp, ctl};
    assign obs1 = {ifc1.state, ifc1.ALUOp, ctl1};

    function automatic logic [22:0] ex(input logic [2:0] s, input logic [4:0] a, input logic [14:0] c);
        return {s, a, c};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.opcode = 6'h00; ifc.func = 6'h00; ifc.mem_ready = 1'b0;
        ifc1.opcode = 6'h00; ifc1.func = 6'h00; ifc1.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== 23'd0) begin n_fail++; $display("FAIL reset_hold got %h exp %h", obs, 23'd0); end
        n_tests++;
        if (obs1 !== 23'd0) begin n_fail++; $display("FAIL reset_hold_md1 got %h exp %h", obs1, 23'd0); end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (obs !== ex(3'd0, A_ADD, MR)) begin n_fail++; $display("FAIL reset_release got %h exp %h", obs, ex(3'd0, A_ADD, MR)); end
        // LW into MEM, stall there, then pulse reset asynchronously
        ifc.opcode = 6'h23; ifc.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ifc.mem_ready = 1'b0;
        #1;
        n_tests++;
        if (obs !== ex(3'd3, A_ADD, IO | AS | MR)) begin n_fail++; $display("FAIL reset_pre_mem got %h exp %h", obs, ex(3'd3, A_ADD, IO | AS | MR)); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 23'd0) begin n_fail++; $display("FAIL reset_async got %h exp %h", obs, 23'd0); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (obs !== ex(3'd0, A_ADD, MR)) begin n_fail++; $display("FAIL reset_mid_release got %h exp %h", obs, ex(3'd0, A_ADD, MR)); end
    endtask

    task automatic test_add();
        logic [22:0] exp [5];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_ADD, 0), ex(5, 0, RW | RD | LK | RT), ex(0, 0, FRDY)};
        ifc.opcode = 6'h00; ifc.func = 6'h20; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL add cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_lw();
        logic [22:0] exp [9];
        bit          rdy [9];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_ADD, AS),
                ex(3, A_ADD, IO | AS | MR), ex(3, A_ADD, IO | AS | MR), ex(3, A_ADD, IO | AS | MR),
                ex(3, A_ADD, IO | AS | MR), ex(5, 0, RW | MT | LK | RT), ex(0, 0, FRDY)};
        rdy = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        ifc.opcode = 6'h23; ifc.func = 6'h00;
        for (int i = 0; i < 9; i++) begin
            ifc.mem_ready = rdy[i];
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL lw cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 8) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_mult();
        logic [22:0] exp [8];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_MULT, 0), ex(4, A_MULT, 0), ex(4, A_MULT, 0),
                ex(4, A_MULT, 0), ex(5, 0, RW | RD | LK | RT), ex(0, 0, FRDY)};
        ifc.opcode = 6'h00; ifc.func = 6'h18; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL mult4 cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 7) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_mult1();
        logic [22:0] exp [5];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_MULT, 0), ex(5, 0, RW | RD | LK | RT), ex(0, 0, FRDY)};
        ifc.mem_ready = 1'b0;
        ifc1.opcode = 6'h00; ifc1.func = 6'h18; ifc1.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (obs1 !== exp[i]) begin n_fail++; $display("FAIL mult1 cyc%0d got %h exp %h", i, obs1, exp[i]); end
            if (i < 4) begin @(posedge clk); #1; end
        end
        ifc1.mem_ready = 1'b0;
    endtask

    task automatic test_jump();
        logic [22:0] exp [7];
        logic [5:0]  opc [7];
        logic [5:0]  fnc [7];
        exp = '{ex(0, 0, FRDY), ex(1, 0, JP | PW | RW | RT), ex(0, 0, FRDY), ex(1, 0, JP | PW | RT),
                ex(0, 0, FRDY), ex(1, 0, JP | JR | PW | RT), ex(0, 0, FRDY)};
        opc = '{6'h03, 6'h03, 6'h02, 6'h02, 6'h00, 6'h00, 6'h00};
        fnc = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h08, 6'h08};
        ifc.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.opcode = opc[i]; ifc.func = fnc[i];
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL jump cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_illegal();
        logic [22:0] exp [5];
        logic [5:0]  opc [5];
        logic [5:0]  fnc [5];
        exp = '{ex(0, 0, FRDY), ex(1, 0, IL), ex(0, 0, FRDY), ex(1, 0, IL), ex(0, 0, FRDY)};
        opc = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        fnc = '{6'h20, 6'h20, 6'h01, 6'h01, 6'h01};
        ifc.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc.opcode = opc[i]; ifc.func = fnc[i];
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL illegal cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch();
        logic [22:0] exp [7];
        logic [5:0]  opc [7];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_CNEQ, BR | RT), ex(0, 0, FRDY),
                ex(1, 0, 0), ex(2, A_CLT, BR | RT), ex(0, 0, FRDY)};
        opc = '{6'h04, 6'h04, 6'h04, 6'h07, 6'h07, 6'h07, 6'h07};
        ifc.func = 6'h00; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.opcode = opc[i];
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL branch cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 6) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_sw();
        logic [22:0] exp [6];
        bit          rdy [6];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_ADD, AS), ex(3, A_ADD, IO | AS | MW),
                ex(3, A_ADD, IO | AS | MW | RT), ex(0, 0, FRDY)};
        rdy = '{1, 1, 1, 0, 1, 1};
        ifc.opcode = 6'h2B; ifc.func = 6'h00;
        for (int i = 0; i < 6; i++) begin
            ifc.mem_ready = rdy[i];
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL sw cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 5) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_imm();
        logic [22:0] exp [9];
        logic [5:0]  opc [9];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_ADD, AS), ex(5, 0, RW | LK | RT), ex(0, 0, FRDY),
                ex(1, 0, 0), ex(2, A_OR, AS), ex(5, 0, RW | LK | RT), ex(0, 0, FRDY)};
        opc = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h0D, 6'h0D, 6'h0D, 6'h0D, 6'h0D};
        ifc.func = 6'h00; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ifc.opcode = opc[i];
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL imm cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 8) begin @(posedge clk); #1; end
        end
    endtask

    // SUB whose IR fields change to LW after DECODE, followed directly by that LW.
    task automatic test_back_to_back();
        logic [22:0] exp [9];
        exp = '{ex(0, 0, FRDY), ex(1, 0, 0), ex(2, A_SUB, 0), ex(5, 0, RW | RD | LK | RT), ex(0, 0, FRDY),
                ex(1, 0, 0), ex(2, A_ADD, AS), ex(3, A_ADD, IO | AS | MR), ex(5, 0, RW | MT | LK | RT)};
        ifc.opcode = 6'h00; ifc.func = 6'h22; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin ifc.opcode = 6'h23; ifc.func = 6'h18; end
            #1;
            n_tests++;
            if (obs !== exp[i]) begin n_fail++; $display("FAIL b2b cyc%0d got %h exp %h", i, obs, exp[i]); end
            if (i < 8) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_mult();
        test_mult1();
        test_jump();
        test_illegal();
        test_branch();
        test_sw();
        test_imm();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle successor to the single-cycle combinational control unit. An FSM sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/MULDIV/WB. It adds memory-ready handshaking, a parametrised multi-cycle MULT/DIV stall, illegal-instruction flagging and a retire pulse. It sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
ALUOP_W, 5, width of ALUOp; values are the existing ALU operation codes.
MULDIV_CYCLES, 4, EXEC+MULDIV cycles for MULT/DIV (legal range 1..16).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from IR, sampled in DECODE
func  in  6  instr[5:0] from IR, sampled in DECODE
mem_ready  in  1  memory access completes this cycle
IorD  out  1  memory address select: 0=PC, 1=ALU result
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC update
Branch  out  1  conditional PC update; datapath gates it with ALU zero
Jump  out  1  PC source = jump target
JumpReg  out  1  jump target = rs (with Jump)
RegDest  out  1  write register = rd (else rt)
MemToReg  out  1  write data = memory data
Link  out  1  1=write ALU/mem result, 0=write PC+4 to $31
ALUsrc  out  1  ALU B = sign-extended immediate
ALUOp  out  ALUOP_W  ALU operation
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write enable
illegal  out  1  1-cycle pulse: unsupported opcode/func
retire  out  1  1-cycle pulse: instruction completed
state  out  3  current state (debug): FETCH=0 DECODE=1 EXEC=2 MEM=3 MULDIV=4 WB=5

Behaviour:
- rst_n low (any time, mid-instruction included): state=FETCH, counter=0, latched opcode/func=0, every output forced 0. After release, FETCH outputs appear combinationally.
- Outputs are combinational from state plus the latched opcode/func. Signals not listed for a state are 0.
- FETCH: IorD=0, MemRead=1. Hold until mem_ready. In the mem_ready cycle, IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
- DECODE: latch opcode/func. Illegal is any opcode outside {R,J,JAL,BEQ,BNE,BLEZ,BGTZ,ADDI,ADDIU,ANDI,ORI,XORI,LW,SW}, or an R-type func outside {SLL,SRL,SRA,SLLV,SRLV,JR,MULT,DIV,ADD,ADDU,SUB,SUBU,AND,OR,XOR,NOR,SLT}.
  - Illegal: illegal=1, go to FETCH, no retire.
  - J: Jump=PCWrite=1, retire=1, go to FETCH.
  - JAL: Jump=PCWrite=RegWrite=1, Link=0, retire=1, go to FETCH.
  - JR: Jump=JumpReg=PCWrite=1, retire=1, go to FETCH.
  - All others: go to EXEC.
- EXEC ALUOp mapping:
  - R-type: per func (SLL/SRL/SRA use the shift-amount variants; SUBU=SUB; ADDU=ADD).
  - I-type: ADD/ADD/AND/OR/XOR for ADDI/ADDIU/ANDI/ORI/XORI.
  - LW/SW: ADD.
  - Branches: BEQ->COMP_NEQ, BNE->COMP_EQ, BLEZ->COMP_GT, BGTZ->COMP_LT. Zero output means taken.
- EXEC ALUsrc: 1 for I-type ALU ops and LW/SW.
- EXEC next state:
  - Branch: Branch=1, retire=1, go to FETCH.
  - MULT/DIV: if MULDIV_CYCLES==1 go to WB; else load counter=MULDIV_CYCLES-2 and go to MULDIV.
  - LW/SW: go to MEM.
  - Others: go to WB.
- MULDIV: ALUOp held. Leave for WB when counter==0, else decrement. Total EXEC+MULDIV cycles equal MULDIV_CYCLES exactly.
- MEM: IorD=1, ALUsrc=1, ALUOp=ADD, MemRead=1 (LW) or MemWrite=1 (SW). Hold until mem_ready.
  - LW goes to WB.
  - SW sets retire=1 in the mem_ready cycle and goes to FETCH.
  - A mem_ready asserted before the request is ignored; only mem_ready sampled while in FETCH/MEM counts.
- WB: one cycle. RegWrite=1, Link=1, retire=1, then go to FETCH.
  - R-type: RegDest=1, MemToReg=0.
  - LW: RegDest=0, MemToReg=1.
  - I-type ALU: RegDest=0, MemToReg=0.
- Latencies with mem_ready tied 1:
  - J/JAL/JR: 2 cycles.
  - Branch: 3 cycles.
  - ALU op: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - MULT/DIV: 3+MULDIV_CYCLES cycles.
- opcode/func changes after DECODE do not affect the instruction in flight.
- Unreachable state codes go to FETCH with all outputs 0.

Test Plan:
- Reset mid-MEM of LW (rst_n low 1 cycle, asynchronous): all outputs 0 immediately, state=0. After release, FETCH with MemRead=1.
- ADD (op 0, func 0x20), mem_ready=1: states 0,1,2,5; WB has RegWrite=RegDest=Link=1, ALUOp=ADD; retire once at cycle 4.
- LW (op 0x23), mem_ready low 3 cycles in MEM: MEM held 4 cycles with IorD=MemRead=1. WB has MemToReg=1, RegDest=0.
- MULT (func 0x18), MULDIV_CYCLES=4 and =1: EXEC+MULDIV span exactly 4 and 1 cycles respectively, then WB.
- JAL (op 3): DECODE cycle has Jump=PCWrite=RegWrite=1, Link=0, retire=1, then FETCH. Opcode 0x3F gives illegal=1, no retire, no RegWrite/MemWrite.
- BEQ (op 4): EXEC has Branch=1, ALUOp=COMP_NEQ, PCWrite=0; SW (op 0x2B) retires on the mem_ready cycle with MemWrite=1 and never asserts RegWrite.
